clock_divider_bank: RTL and testbench

//  Multi-channel slow-clock / tick generator: CHANNELS independent dividers off one fast clock, each

---
 rtl/clock_divider_bank.sv | 83 ++++++++
 tb/tb_clock_divider_bank.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of independent programmable clock dividers with tick outputs
module clock_divider_bank #(
    parameter int F_CLK       = 50000000,
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 32,
    parameter int DEFAULT_DIV = F_CLK,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clk_slow,
    output logic [CHANNELS-1:0] one_pulse
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

    logic [DIV_W-1:0]    act_div   [CHANNELS];
    logic [DIV_W-1:0]    shd_div   [CHANNELS];
    logic [DIV_W-1:0]    cnt       [CHANNELS];
    logic [DIV_W-1:0]    act_div_n [CHANNELS];
    logic [DIV_W-1:0]    shd_div_n [CHANNELS];
    logic [DIV_W-1:0]    cnt_n     [CHANNELS];
    logic [CHANNELS-1:0] clk_slow_n;
    logic [CHANNELS-1:0] one_pulse_n;
    logic [DIV_W-1:0]    wr_div;
    logic                cfg_ok;

    always_comb begin
        wr_div      = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
        cfg_ok      = int'(cfg_ch) < CHANNELS;
        clk_slow_n  = '0;
        one_pulse_n = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            act_div_n[i] = act_div[i];
            shd_div_n[i] = shd_div[i];
            cnt_n[i]     = cnt[i];
            if (cfg_we && cfg_ok && (cfg_ch == CH_W'(i))) begin
                shd_div_n[i] = wr_div;
            end
            if (!en[i]) begin
                // Parked one short of the period so the first enabled edge wraps and ticks.
                act_div_n[i] = shd_div[i];
                cnt_n[i]     = shd_div[i] - 1'b1;
            end else begin
                if ((cnt[i] == act_div[i] - 1'b1) || sync) begin
                    cnt_n[i]     = '0;
                    act_div_n[i] = shd_div[i];
                end else begin
                    cnt_n[i] = cnt[i] + 1'b1;
                end
                clk_slow_n[i]  = cnt_n[i] < (act_div_n[i] - (act_div_n[i] >> 1));
                one_pulse_n[i] = (cnt_n[i] == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                act_div[i] <= DEF_DIV;
                shd_div[i] <= DEF_DIV;
                cnt[i]     <= DEF_DIV - 1'b1;
            end
            clk_slow  <= '0;
            one_pulse <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                act_div[i] <= act_div_n[i];
                shd_div[i] <= shd_div_n[i];
                cnt[i]     <= cnt_n[i];
            end
            clk_slow  <= clk_slow_n;
            one_pulse <= one_pulse_n;
        end
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - self-checking bench for clock_divider_bank
module tb_clock_divider_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic       sync;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] clk_slow;
    logic [3:0] one_pulse;

    always #5 clk = ~clk;

    clock_divider_bank #(
        .F_CLK(10), .CHANNELS(4), .DIV_W(8), .DEFAULT_DIV(10)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_slow(clk_slow), .one_pulse(one_pulse)
    );

    int total = 0;
    int bad   = 0;

    // Reference: each channel is "age since last tick" within a period, plus a pending period.
    int         m_cur  [4];
    int         m_pend [4];
    int         m_age  [4];
    bit         m_run  [4];
    logic [3:0] m_slow;
    logic [3:0] m_pulse;

    typedef struct {
        logic [3:0] en;
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic [3:0] exp_slow;
        logic [3:0] exp_pulse;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_cur[i] = 10; m_pend[i] = 10; m_age[i] = 0; m_run[i] = 0;
            end
            m_slow = '0; m_pulse = '0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            int old_pend;
            old_pend = m_pend[i];
            if (cfg_we && int'(cfg_ch) == i) m_pend[i] = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
            if (!en[i]) begin
                m_cur[i] = old_pend; m_run[i] = 0; m_slow[i] = 1'b0; m_pulse[i] = 1'b0;
            end else begin
                if (!m_run[i] || sync || m_age[i] == m_cur[i] - 1) begin
                    m_age[i] = 0; m_cur[i] = old_pend; m_run[i] = 1;
                end else begin
                    m_age[i]++;
                end
                m_slow[i]  = m_age[i] < (m_cur[i] + 1) / 2;
                m_pulse[i] = (m_age[i] == 0);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model_slow", clk_slow, m_slow);
        check("model_pulse", one_pulse, m_pulse);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 1'b1, 2'd1, 8'd3, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010};
        vecs[2]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0000};
        vecs[3]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010};
        vecs[5]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0000};
        vecs[6]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010};
        vecs[8]  = '{4'b0010, 1'b1, 2'd1, 8'd0, 4'b0010, 4'b0000};
        vecs[9]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000};
        vecs[10] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010};
        vecs[11] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000};
        vecs[12] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010};
        vecs[13] = '{4'b0010, 1'b1, 2'd1, 8'd1, 4'b0000, 4'b0000};
        vecs[14] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010};
        vecs[15] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000};

        do_reset();
        check("reset_slow", clk_slow, 4'b0000);
        check("reset_pulse", one_pulse, 4'b0000);

        // Default period 10 on ch0 only
        en = 4'b0001;
        for (int t = 0; t < 20; t++) begin
            cyc();
            check("s1_slow", clk_slow, {3'b000, (t % 10) < 5});
            check("s1_pulse", one_pulse, {3'b000, (t % 10) == 0});
        end

        // Period change mid-period completes the current period first
        for (int t = 0; t < 4; t++) cyc();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        cyc();
        cfg_we = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            int pos;
            int per;
            cyc();
            if (j < 6) begin pos = j + 4; per = 10; end
            else begin pos = (j - 6) % 4; per = 4; end
            if (j <= 16) begin
                check("s3_slow", clk_slow, {3'b000, pos < (per + 1) / 2});
                check("s3_pulse", one_pulse, {3'b000, pos == 0});
            end
        end
        // Write landing on a wrap edge: old pending period used for one more period
        cfg_we = 1'b1; cfg_div = 8'd6;
        cyc();
        cfg_we = 1'b0;
        check("s3_wrap_pulse", one_pulse, 4'b0001);
        for (int k = 1; k <= 12; k++) begin
            int pos;
            int per;
            cyc();
            if (k < 4) begin pos = k; per = 4; end
            else begin pos = (k - 4) % 6; per = 6; end
            check("s3b_slow", clk_slow, {3'b000, pos < (per + 1) / 2});
            check("s3b_pulse", one_pulse, {3'b000, pos == 0});
        end

        // Table: ch1 P=3, then clamped divisors 0 and 1 behave as P=2
        do_reset();
        for (int v = 0; v < 16; v++) begin
            en = vecs[v].en; cfg_we = vecs[v].we; cfg_ch = vecs[v].ch; cfg_div = vecs[v].div;
            cyc();
            check("tbl_slow", clk_slow, vecs[v].exp_slow);
            check("tbl_pulse", one_pulse, vecs[v].exp_pulse);
        end
        cfg_we = 1'b0;

        // Sync aligns ch0 (P=10) and ch2 (P=7)
        do_reset();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd7;
        cyc();
        cfg_we = 1'b0;
        en = 4'b0001;
        for (int t = 0; t < 3; t++) cyc();
        en = 4'b0101;
        for (int t = 0; t < 5; t++) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("s5_sync_pulse", one_pulse, 4'b0101);
        for (int k = 1; k <= 21; k++) begin
            cyc();
            check("s5_pulse", one_pulse, {1'b0, (k % 7) == 0, 1'b0, (k % 10) == 0});
        end
        en = 4'b0000;
        cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("s5_sync_disabled", one_pulse, 4'b0000);

        // en drop mid-high, then rst mid-period restores default period
        do_reset();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd3;
        cyc();
        cfg_we = 1'b0;
        en = 4'b1001;
        for (int t = 0; t < 3; t++) cyc();
        en = 4'b1000;
        cyc();
        check("s6_en_drop", clk_slow & 4'b0001, 4'b0000);
        en = 4'b1001;
        for (int t = 0; t < 4; t++) cyc();
        rst = 1'b1;
        cyc();
        check("s6_rst_slow", clk_slow, 4'b0000);
        check("s6_rst_pulse", one_pulse, 4'b0000);
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            cyc();
            check("s6_def_slow", clk_slow, {(t % 10) < 5, 2'b00, (t % 10) < 5});
        end

        // Randomized traffic against the reference model
        en = '0;
        for (int n = 0; n < 4000; n++) begin
            rst    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) en = 4'($urandom);
            sync   = ($urandom_range(0, 29) == 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_ch = 2'($urandom);
            cfg_div = 8'($urandom_range(0, 12));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
